uart_frame_sched: RTL and testbench

UART_FRAME_SCHED -- requirements
Module: uart_frame_sched

---
 rtl/uart_frame_sched_pkg.sv | 26 ++
 rtl/frame_crc8.sv | 34 +++
 rtl/uart_frame_sched.sv | 197 +++++++++++++++++++
 tb/tb_uart_frame_sched.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_sched_pkg.sv
// Shared types and constants for the UART frame scheduler.
package uart_frame_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_HI,
    WAIT_LO,
    DONE
  } state_e;

  localparam int         FRAME_LEN   = 4;
  localparam logic [7:0] CRC_POLY    = 8'h07;
  localparam logic [7:0] SOF_DEFAULT = 8'h7E;

  // One full byte of CRC-8, MSB first, no reflection.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/frame_crc8.sv
// Registered CRC-8 accumulator: clear has priority over update, one byte per cycle.
module frame_crc8
  import uart_frame_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       update,
  input  logic [7:0] data_in,
  output logic [7:0] crc
);

  logic [7:0] crc_d, crc_q;

  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = '0;
    end else if (update) begin
      crc_d = crc8_step(crc_q, data_in);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/uart_frame_sched.sv
// Round-robin scheduler that wraps one requester byte per frame (SOF, header, payload, CRC8) for uart_tx.
// Optional watchdog on the tx_busy handshake is enabled by defining UART_SCHED_TIMEOUT_EN.
module uart_frame_sched
  import uart_frame_sched_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE       = SOF_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  output logic [1:0] gnt,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_src,
  output logic       frame_err
);

  localparam logic [1:0] LAST_IDX = 2'(FRAME_LEN - 1);

  state_e     state_d, state_q;
  logic [1:0] byte_idx_d, byte_idx_q;
  logic       last_d, last_q;
  logic [7:0] payload_d, payload_q;
  logic       src_d, src_q;
  logic [1:0] gnt_d, gnt_q;
  logic       tx_start_d, tx_start_q;
  logic [7:0] tx_data_d, tx_data_q;
  logic       busy_d, busy_q;
  logic       frame_done_d, frame_done_q;
  logic       frame_err_d, frame_err_q;

  logic       crc_clear, crc_update;
  logic [7:0] crc_val;
  logic [7:0] cur_byte;
  logic       arb_win;
  logic       timeout_hit;

  frame_crc8 u_crc (
    .clk     (clk),
    .reset   (reset),
    .clear   (crc_clear),
    .update  (crc_update),
    .data_in (cur_byte),
    .crc     (crc_val)
  );

`ifdef UART_SCHED_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] to_cnt_d, to_cnt_q;
  logic        in_wait;

  // Counter restarts every time a byte is launched, so the limit is per byte.
  assign in_wait = (state_q == WAIT_HI) || (state_q == WAIT_LO);
  always_comb begin
    to_cnt_d = '0;
    if (in_wait) begin
      to_cnt_d = to_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign timeout_hit = in_wait && (to_cnt_q == TO_LAST);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  // With both requesting, the one not served last wins; otherwise the single requester.
  assign arb_win = (req == 2'b11) ? ~last_q : req[1];

  always_comb begin
    case (byte_idx_q)
      2'd0:    cur_byte = SOF_BYTE;
      2'd1:    cur_byte = {7'b0, src_q};
      2'd2:    cur_byte = payload_q;
      default: cur_byte = crc_val;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    last_d       = last_q;
    payload_d    = payload_q;
    src_d        = src_q;
    gnt_d        = 2'b00;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    crc_clear    = 1'b0;
    crc_update   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          gnt_d      = arb_win ? 2'b10 : 2'b01;
          src_d      = arb_win;
          payload_d  = arb_win ? req_data1 : req_data0;
          crc_clear  = 1'b1;
          byte_idx_d = 2'd0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = cur_byte;
          crc_update = (byte_idx_q == 2'd1) || (byte_idx_q == 2'd2);
          state_d    = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (timeout_hit) begin
          frame_err_d = 1'b1;
          last_d      = src_q;
          state_d     = IDLE;
        end else if (tx_busy) begin
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (timeout_hit) begin
          frame_err_d = 1'b1;
          last_d      = src_q;
          state_d     = IDLE;
        end else if (!tx_busy) begin
          if (byte_idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = SEND;
          end
        end
      end
      DONE: begin
        frame_done_d = 1'b1;
        last_d       = src_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      byte_idx_q   <= 2'd0;
      last_q       <= 1'b1;
      payload_q    <= '0;
      src_q        <= 1'b0;
      gnt_q        <= 2'b00;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      last_q       <= last_d;
      payload_q    <= payload_d;
      src_q        <= src_d;
      gnt_q        <= gnt_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign gnt        = gnt_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign frame_src  = src_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_frame_sched.sv
// Randomised bench for uart_frame_sched with a frame-level reference model and a tx_busy responder.
module tb_uart_frame_sched;

  localparam int TO_CYC = 50;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [7:0] d0, d1;
  logic [1:0] gnt;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy, frame_done, frame_src, frame_err;

  uart_frame_sched #(.SOF_BYTE(8'h7E), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_data0  (d0),
    .req_data1  (d1),
    .gnt        (gnt),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_src  (frame_src),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bit-serial CRC-8, polynomial 0x07, MSB first.
  function automatic logic [7:0] crc_ref(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] r;
    logic       fb;
    r = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = r[7] ^ b[i];
      r  = {r[6:0], 1'b0};
      if (fb) r = r ^ 8'h07;
    end
    return r;
  endfunction

  // uart_tx stand-in knobs
  int busy_min  = 10;
  int busy_max  = 10;
  bit stalls_en = 1'b0;
  bit stuck     = 1'b0;

  initial begin
    int cnt;
    int stall;
    bit gap;
    cnt = 0; stall = 0; gap = 1'b0;
    tx_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        cnt = 0; stall = 0; gap = 1'b0; tx_busy = 1'b0;
      end else begin
        if (tx_start) cnt = $urandom_range(busy_max, busy_min);
        if (cnt > 0) begin
          tx_busy = 1'b1;
          cnt--;
          if (cnt == 0) gap = stalls_en && ($urandom_range(3, 0) == 0);
        end else if (stall > 0) begin
          tx_busy = 1'b1;
          stall--;
        end else if (gap) begin
          tx_busy = 1'b0;
          gap     = 1'b0;
          stall   = $urandom_range(4, 1);
        end else begin
          tx_busy = 1'b0;
        end
        if (stuck) tx_busy = 1'b1;
      end
    end
  end

  // Reference model state
  bit         m_idle = 1'b1;
  bit         m_last = 1'b1;
  bit         m_src  = 1'b0;
  logic [7:0] m_txd  = 8'h00;
  logic [7:0] m_bytes [4];
  int         m_n = 0;
  int         since_start = 0;
  bit         p_idle = 1'b1, p_rst = 1'b1, p_busy = 1'b0, p_gnt = 1'b0;
  logic [1:0] p_req = 2'b00;
  logic [7:0] p_d0 = 8'h00, p_d1 = 8'h00;
  logic [1:0] c_eg;
  bit         c_win;

  logic [7:0] txlog [$];
  logic [1:0] gntlog [$];
  int         done_cnt = 0;
  int         err_cnt  = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("reset_outputs", 32'({gnt, tx_start, tx_data, busy, frame_done, frame_src, frame_err}), 32'd0);
        m_idle = 1'b1; m_last = 1'b1; m_src = 1'b0; m_txd = 8'h00; m_n = 0;
        p_rst = 1'b1; p_idle = 1'b1; p_gnt = 1'b0; p_busy = tx_busy;
        p_req = req; p_d0 = d0; p_d1 = d1;
      end else begin
        since_start++;
        c_win = (p_req == 2'b11) ? ~m_last : p_req[1];
        c_eg  = (!p_rst && p_idle && p_req != 2'b00) ? (c_win ? 2'b10 : 2'b01) : 2'b00;
        chk("gnt", 32'(gnt), 32'(c_eg));
        if (p_gnt && !p_busy) chk("first_start_latency", 32'(tx_start), 32'd1);
        if (c_eg != 2'b00) begin
          gntlog.push_back(c_eg);
          m_idle     = 1'b0;
          m_src      = c_win;
          m_n        = 0;
          m_bytes[0] = 8'h7E;
          m_bytes[1] = {7'b0, c_win};
          m_bytes[2] = c_win ? p_d1 : p_d0;
          m_bytes[3] = crc_ref(crc_ref(8'h00, m_bytes[1]), m_bytes[2]);
        end
        if (tx_start) begin
          chk("tx_start_in_frame", 32'(!m_idle && m_n < 4), 32'd1);
          chk("tx_start_busy_low", 32'(p_busy), 32'd0);
          if (m_n < 4) begin
            chk("tx_byte", 32'(tx_data), 32'(m_bytes[m_n]));
            m_n++;
          end
          m_txd = tx_data;
          txlog.push_back(tx_data);
          since_start = 0;
        end else begin
          chk("tx_data_hold", 32'(tx_data), 32'(m_txd));
        end
        if (frame_done) begin
          chk("done_after_crc", 32'(!m_idle && m_n == 4), 32'd1);
          m_idle = 1'b1;
          m_last = m_src;
          done_cnt++;
        end
`ifdef UART_SCHED_TIMEOUT_EN
        if (frame_err) begin
          chk("err_in_frame", 32'(!m_idle), 32'd1);
          chk("err_timing", 32'(since_start >= TO_CYC - 2 && since_start <= TO_CYC + 2), 32'd1);
          m_idle = 1'b1;
          m_last = m_src;
          err_cnt++;
        end
`else
        chk("frame_err_tied", 32'(frame_err), 32'd0);
`endif
        chk("busy", 32'(busy), 32'(!m_idle));
        chk("frame_src", 32'(frame_src), 32'(m_src));
        p_rst  = 1'b0;
        p_idle = m_idle;
        p_gnt  = (c_eg != 2'b00);
        p_busy = tx_busy;
        p_req  = req;
        p_d0   = d0;
        p_d1   = d1;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic wait_gnts(input int target, input int budget);
    int i;
    i = 0;
    while (gntlog.size() < target && i < budget) begin tick(); i++; end
    chk("wait_gnt_timeout", 32'(gntlog.size() >= target), 32'd1);
  endtask

  task automatic wait_done(input int target, input int budget);
    int i;
    i = 0;
    while (done_cnt < target && i < budget) begin tick(); i++; end
    chk("wait_done_timeout", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic wait_bytes(input int target, input int budget);
    int i;
    i = 0;
    while (txlog.size() < target && i < budget) begin tick(); i++; end
    chk("wait_bytes_timeout", 32'(txlog.size() >= target), 32'd1);
  endtask

  task automatic clear_logs();
    txlog.delete();
    gntlog.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int i;
    reset = 1'b1; req = 2'b00; d0 = 8'h00; d1 = 8'h00;
    tick(3);
    reset = 1'b0;
    tick(2);

    // Requester 0 alone, payload changed right after the grant
    busy_min = 10; busy_max = 10; stalls_en = 1'b0;
    clear_logs();
    req = 2'b01; d0 = 8'hA5; d1 = 8'h5A;
    wait_gnts(1, 50);
    req = 2'b00; d0 = 8'h3C;
    wait_done(1, 200);
    tick(5);
    chk("A_count", 32'(txlog.size()), 32'd4);
    if (txlog.size() == 4) chk("A_bytes", {txlog[0], txlog[1], txlog[2], txlog[3]}, 32'h7E00A572);
    chk("A_done", 32'(done_cnt), 32'd1);
    chk("A_src", 32'(frame_src), 32'd0);

    // Requester 1 alone, zero payload
    clear_logs();
    req = 2'b10; d1 = 8'h00;
    wait_gnts(1, 50);
    req = 2'b00; d1 = 8'hFF;
    wait_done(1, 200);
    tick(5);
    chk("B_count", 32'(txlog.size()), 32'd4);
    if (txlog.size() == 4) chk("B_bytes", {txlog[0], txlog[1], txlog[2], txlog[3]}, 32'h7E010015);
    chk("B_src", 32'(frame_src), 32'd1);

    // Both requesting for three frames
    busy_min = 2; busy_max = 6;
    clear_logs();
    req = 2'b11; d0 = 8'h11; d1 = 8'h22;
    wait_gnts(3, 600);
    req = 2'b00;
    wait_done(3, 600);
    tick(5);
    chk("C_gnt_count", 32'(gntlog.size()), 32'd3);
    if (gntlog.size() == 3) chk("C_order", 32'({gntlog[0], gntlog[1], gntlog[2]}), 32'b01_10_01);
    chk("C_done", 32'(done_cnt), 32'd3);

    // tx_busy stuck high after the SOF byte
    busy_min = 10; busy_max = 10;
    clear_logs();
    req = 2'b01; d0 = 8'(($urandom));
    wait_bytes(1, 50);
    stuck = 1'b1;
    req = 2'b00;
`ifdef UART_SCHED_TIMEOUT_EN
    i = 0;
    while (err_cnt < 1 && i < 200) begin tick(); i++; end
    chk("D_err_seen", 32'(err_cnt), 32'd1);
    tick(2);
    chk("D_idle_after_err", 32'(busy), 32'd0);
    stuck = 1'b0;
    tick(15);
    chk("D_no_done", 32'(done_cnt), 32'd0);
`else
    tick(200);
    chk("D_busy_held", 32'(busy), 32'd1);
    chk("D_no_done_yet", 32'(done_cnt), 32'd0);
    stuck = 1'b0;
    wait_done(1, 200);
`endif
    tick(5);

    // Reset during the payload byte
    clear_logs();
    req = 2'b10; d1 = 8'h99;
    wait_bytes(3, 200);
    req = 2'b00;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("E_reset_now", 32'({gnt, tx_start, tx_data, busy, frame_done, frame_src, frame_err}), 32'd0);
    tick(2);
    gntlog.delete();
    done_cnt = 0;
    req = 2'b11; d0 = 8'h42; d1 = 8'h24;
    reset = 1'b0;
    wait_gnts(1, 50);
    if (gntlog.size() >= 1) chk("E_first_after_reset", 32'(gntlog[0]), 32'b01);
    req = 2'b00;
    wait_done(1, 200);
    tick(3);

    // Randomised traffic with stalls
    busy_min = 1; busy_max = 12; stalls_en = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(15, 0) == 0) req = 2'($urandom_range(3, 0));
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      tick();
    end
    req = 2'b00;
    i = 0;
    while (busy && i < 300) begin tick(); i++; end
    chk("F_drain_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
